// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between the MEM stage (master) and the data memory controller (slave).
interface data_mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_fault;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// RISC-V data memory: byte/half/word loads and stores, fault detection, hardware clear
// after reset and a fixed-latency, fully pipelined response path.
module data_mem_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 1024,
  parameter int READ_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  data_mem_ctrl_if.slave  bus,
  output logic            init_done
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  logic [IDX_W-1:0]  clr_idx;
  logic              ready_q;
  logic [31:0]       mem [DEPTH];

  logic              accept;
  logic [IDX_W-1:0]  widx;
  logic [1:0]        lane;
  logic              out_of_range;
  logic              fault;
  logic [31:0]       cur_word;
  logic [31:0]       shifted;
  logic [31:0]       load_data;
  logic [31:0]       wdata_sh;
  logic [3:0]        be;

  logic              pipe_valid [READ_LAT];
  logic [31:0]       pipe_rdata [READ_LAT];
  logic              pipe_fault [READ_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      clr_idx   <= '0;
      ready_q   <= 1'b0;
      init_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          clr_idx <= clr_idx + IDX_W'(1);
          if (clr_idx == IDX_W'(DEPTH - 1)) begin
            state     <= RUN;
            ready_q   <= 1'b1;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          ready_q   <= 1'b1;
          init_done <= 1'b1;
        end
        default: state <= INIT;
      endcase
    end
  end

  assign accept       = bus.req_valid && ready_q;
  assign widx         = bus.req_addr[IDX_W+1:2];
  assign lane         = bus.req_addr[1:0];
  assign out_of_range = (bus.req_addr >> (IDX_W + 2)) != '0;
  assign fault        = (bus.req_size == 2'b11)
                     || (bus.req_size == 2'b01 && lane[0])
                     || (bus.req_size == 2'b10 && lane != 2'b00)
                     || out_of_range;

  // Lane alignment of both directions: loads shift down, stores shift up with byte enables.
  always_comb begin
    cur_word  = mem[widx];
    shifted   = cur_word >> {lane, 3'b000};
    wdata_sh  = bus.req_wdata << {lane, 3'b000};
    be        = 4'b0000;
    load_data = '0;
    case (bus.req_size)
      2'b00: begin
        be        = 4'b0001 << lane;
        load_data = bus.req_unsigned ? {24'b0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        be        = 4'b0011 << lane;
        load_data = bus.req_unsigned ? {16'b0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
      end
      2'b10: begin
        be        = 4'b1111;
        load_data = shifted;
      end
      default: begin
        be        = 4'b0000;
        load_data = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        mem[clr_idx] <= '0;
      end else if (accept && bus.req_we && !fault) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem[widx][8*b +: 8] <= wdata_sh[8*b +: 8];
        end
      end
    end
  end

  // Stage 0 captures the result at the accept edge; later stages only add delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LAT; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_rdata[i] <= '0;
        pipe_fault[i] <= 1'b0;
      end
    end else begin
      pipe_valid[0] <= accept;
      pipe_rdata[0] <= (accept && !bus.req_we && !fault) ? load_data : 32'h0;
      pipe_fault[0] <= accept && fault;
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_rdata[i] <= pipe_rdata[i-1];
        pipe_fault[i] <= pipe_fault[i-1];
      end
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = pipe_valid[READ_LAT-1];
  assign bus.rsp_rdata = pipe_rdata[READ_LAT-1];
  assign bus.rsp_fault = pipe_fault[READ_LAT-1];
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench: one controller at READ_LAT=1 and one at READ_LAT=3 share the same request
// stream, so their memories stay identical while their response timing differs.
module tb_data_mem_ctrl;
  localparam int DEPTH = 16;

  logic clk;
  logic rst;
  logic init_done_a;
  logic init_done_b;
  int   tests;
  int   fails;

  data_mem_ctrl_if #(.ADDR_W(32)) ia ();
  data_mem_ctrl_if #(.ADDR_W(32)) ib ();

  assign ib.req_valid    = ia.req_valid;
  assign ib.req_we       = ia.req_we;
  assign ib.req_size     = ia.req_size;
  assign ib.req_unsigned = ia.req_unsigned;
  assign ib.req_addr     = ia.req_addr;
  assign ib.req_wdata    = ia.req_wdata;

  data_mem_ctrl #(.ADDR_W(32), .DEPTH(DEPTH), .READ_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .bus(ia), .init_done(init_done_a)
  );

  data_mem_ctrl #(.ADDR_W(32), .DEPTH(DEPTH), .READ_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .bus(ib), .init_done(init_done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One request on the latency-1 controller; its response is due right after the accept edge.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [33:0] rsp);
    ia.req_valid    = 1'b1;
    ia.req_we       = we;
    ia.req_size     = size;
    ia.req_unsigned = uns;
    ia.req_addr     = addr;
    ia.req_wdata    = wdata;
    @(posedge clk);
    #1;
    ia.req_valid = 1'b0;
    rsp = {ia.rsp_valid, ia.rsp_fault, ia.rsp_rdata};
  endtask

  task automatic test_reset();
    int n;
    logic [33:0] rsp;
    tests++;
    if ({ia.req_ready, ia.rsp_valid, ia.rsp_fault, ia.rsp_rdata, init_done_a} !== 36'h0) begin
      fails++;
      $display("[TB] FAIL reset_a: got ready=%b valid=%b fault=%b rdata=%h done=%b, want all 0",
               ia.req_ready, ia.rsp_valid, ia.rsp_fault, ia.rsp_rdata, init_done_a);
    end
    tests++;
    if ({ib.req_ready, ib.rsp_valid, ib.rsp_fault, ib.rsp_rdata, init_done_b} !== 36'h0) begin
      fails++;
      $display("[TB] FAIL reset_b: got ready=%b valid=%b fault=%b rdata=%h done=%b, want all 0",
               ib.req_ready, ib.rsp_valid, ib.rsp_fault, ib.rsp_rdata, init_done_b);
    end
    rst = 1'b0;
    n = 0;
    while (ia.req_ready !== 1'b1 && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    tests++;
    if (n != DEPTH) begin
      fails++;
      $display("[TB] FAIL init_len: got %0d not-ready cycles, want %0d", n, DEPTH);
    end
    tests++;
    if ({init_done_a, ib.req_ready, init_done_b} !== 3'b111) begin
      fails++;
      $display("[TB] FAIL init_done: got done_a=%b ready_b=%b done_b=%b, want 1 1 1",
               init_done_a, ib.req_ready, init_done_b);
    end
    issue(1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, rsp);
    tests++;
    if (rsp !== {2'b10, 32'h0}) begin
      fails++;
      $display("[TB] FAIL cleared_lw_3c: got %h, want %h", rsp, {2'b10, 32'h0});
    end
  endtask

  task automatic test_byte();
    logic [33:0] rsp;
    logic [31:0] addr_t [6] = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h13, 32'h11};
    logic        uns_t  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] exp_t  [6] = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF,
                                32'hFFFFFF80, 32'h00000080, 32'h0000007F};
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF7F01, rsp);
    tests++;
    if (rsp !== {2'b10, 32'h0}) begin
      fails++;
      $display("[TB] FAIL sw_ack: got %h, want %h", rsp, {2'b10, 32'h0});
    end
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, 2'b00, uns_t[i], addr_t[i], 32'h0, rsp);
      tests++;
      if (rsp !== {2'b10, exp_t[i]}) begin
        fails++;
        $display("[TB] FAIL lb_%0d @%h uns=%b: got %h, want %h",
                 i, addr_t[i], uns_t[i], rsp, {2'b10, exp_t[i]});
      end
    end
    issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h123456AA, rsp);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rsp);
    tests++;
    if (rsp !== {2'b10, 32'h80FFAA01}) begin
      fails++;
      $display("[TB] FAIL sb_merge: got %h, want %h", rsp, {2'b10, 32'h80FFAA01});
    end
  endtask

  task automatic test_half();
    logic [33:0] rsp;
    logic [31:0] addr_t [4] = '{32'h20, 32'h22, 32'h22, 32'h20};
    logic [1:0]  size_t [4] = '{2'b10, 2'b01, 2'b01, 2'b01};
    logic        uns_t  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] exp_t  [4] = '{32'hBEEF3344, 32'hFFFFBEEF, 32'h0000BEEF, 32'h00003344};
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, rsp);
    issue(1'b1, 2'b01, 1'b0, 32'h22, 32'hCAFEBEEF, rsp);
    tests++;
    if (rsp !== {2'b10, 32'h0}) begin
      fails++;
      $display("[TB] FAIL sh_ack: got %h, want %h", rsp, {2'b10, 32'h0});
    end
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, size_t[i], uns_t[i], addr_t[i], 32'h0, rsp);
      tests++;
      if (rsp !== {2'b10, exp_t[i]}) begin
        fails++;
        $display("[TB] FAIL half_%0d @%h: got %h, want %h", i, addr_t[i], rsp, {2'b10, exp_t[i]});
      end
    end
  endtask

  task automatic test_fault();
    logic [33:0] rsp;
    logic        we_t   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0]  size_t [7] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b01, 2'b10, 2'b00};
    logic        uns_t  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] addr_t [7] = '{32'h21, 32'h23, 32'h20, 32'h40, 32'h21, 32'h21, 32'h40};
    for (int i = 0; i < 7; i++) begin
      issue(we_t[i], size_t[i], uns_t[i], addr_t[i], 32'hDEADBE55, rsp);
      tests++;
      if (rsp !== {2'b11, 32'h0}) begin
        fails++;
        $display("[TB] FAIL fault_%0d @%h size=%b: got %h, want %h",
                 i, addr_t[i], size_t[i], rsp, {2'b11, 32'h0});
      end
    end
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rsp);
    tests++;
    if (rsp !== {2'b10, 32'hBEEF3344}) begin
      fails++;
      $display("[TB] FAIL fault_sw_nowrite: got %h, want %h", rsp, {2'b10, 32'hBEEF3344});
    end
    issue(1'b0, 2'b10, 1'b0, 32'h00, 32'h0, rsp);
    tests++;
    if (rsp !== {2'b10, 32'h0}) begin
      fails++;
      $display("[TB] FAIL oor_sb_nowrap: got %h, want %h", rsp, {2'b10, 32'h0});
    end
  endtask

  task automatic test_back_to_back();
    ia.req_valid    = 1'b1;
    ia.req_we       = 1'b1;
    ia.req_size     = 2'b10;
    ia.req_unsigned = 1'b0;
    ia.req_addr     = 32'h30;
    ia.req_wdata    = 32'hA5A5F00D;
    @(posedge clk);
    #1;
    tests++;
    if ({ia.rsp_valid, ia.rsp_fault, ia.rsp_rdata} !== {2'b10, 32'h0}) begin
      fails++;
      $display("[TB] FAIL b2b_store_ack: got %b %b %h, want 1 0 00000000",
               ia.rsp_valid, ia.rsp_fault, ia.rsp_rdata);
    end
    ia.req_we = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if ({ia.rsp_valid, ia.rsp_fault, ia.rsp_rdata} !== {2'b10, 32'hA5A5F00D}) begin
      fails++;
      $display("[TB] FAIL b2b_load: got %b %b %h, want 1 0 a5a5f00d",
               ia.rsp_valid, ia.rsp_fault, ia.rsp_rdata);
    end
    ia.req_size     = 2'b00;
    ia.req_unsigned = 1'b1;
    ia.req_addr     = 32'h31;
    @(posedge clk);
    #1;
    ia.req_valid = 1'b0;
    tests++;
    if ({ia.rsp_valid, ia.rsp_fault, ia.rsp_rdata} !== {2'b10, 32'h000000F0}) begin
      fails++;
      $display("[TB] FAIL b2b_lbu: got %b %b %h, want 1 0 000000f0",
               ia.rsp_valid, ia.rsp_fault, ia.rsp_rdata);
    end
  endtask

  task automatic test_pipeline();
    logic [31:0] addr_t [5] = '{32'h10, 32'h13, 32'h22, 32'h20, 32'h30};
    logic [1:0]  size_t [5] = '{2'b10, 2'b00, 2'b01, 2'b10, 2'b00};
    logic        uns_t  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] exp_t  [5] = '{32'h80FFAA01, 32'h00000080, 32'hFFFFBEEF,
                                32'hBEEF3344, 32'h0000000D};
    logic [33:0] want;
    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < 10; k++) begin
      if (k < 5) begin
        ia.req_valid    = 1'b1;
        ia.req_we       = 1'b0;
        ia.req_size     = size_t[k];
        ia.req_unsigned = uns_t[k];
        ia.req_addr     = addr_t[k];
      end else begin
        ia.req_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      want = (k >= 2 && k <= 6) ? {2'b10, exp_t[k-2]} : 34'h0;
      tests++;
      if ({ib.rsp_valid, ib.rsp_fault, ib.rsp_rdata} !== want) begin
        fails++;
        $display("[TB] FAIL lat3_cycle%0d: got %b %b %h, want %h",
                 k, ib.rsp_valid, ib.rsp_fault, ib.rsp_rdata, want);
      end
    end
  endtask

  task automatic test_reset_in_flight();
    int n;
    int stray;
    logic [33:0] rsp;
    ia.req_valid    = 1'b1;
    ia.req_we       = 1'b0;
    ia.req_size     = 2'b10;
    ia.req_unsigned = 1'b0;
    ia.req_addr     = 32'h10;
    @(posedge clk);
    #1;
    ia.req_addr = 32'h20;
    @(posedge clk);
    #1;
    ia.req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0;
    stray = 0;
    while (ia.req_ready !== 1'b1 && n < 100) begin
      if (ia.rsp_valid !== 1'b0 || ib.rsp_valid !== 1'b0) stray++;
      n++;
      @(posedge clk);
      #1;
    end
    tests++;
    if (stray != 0) begin
      fails++;
      $display("[TB] FAIL flush: got %0d cycles with rsp_valid after reset, want 0", stray);
    end
    tests++;
    if (n != DEPTH) begin
      fails++;
      $display("[TB] FAIL reinit_len: got %0d not-ready cycles, want %0d", n, DEPTH);
    end
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rsp);
    tests++;
    if (rsp !== {2'b10, 32'h0}) begin
      fails++;
      $display("[TB] FAIL recleared_10: got %h, want %h", rsp, {2'b10, 32'h0});
    end
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rsp);
    tests++;
    if (rsp !== {2'b10, 32'h0}) begin
      fails++;
      $display("[TB] FAIL recleared_20: got %h, want %h", rsp, {2'b10, 32'h0});
    end
  endtask

  initial begin
    tests           = 0;
    fails           = 0;
    rst             = 1'b1;
    ia.req_valid    = 1'b0;
    ia.req_we       = 1'b0;
    ia.req_size     = 2'b00;
    ia.req_unsigned = 1'b0;
    ia.req_addr     = '0;
    ia.req_wdata    = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_byte();
    test_half();
    test_fault();
    test_back_to_back();
    test_pipeline();
    test_reset_in_flight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
